sample_trigger_arbiter: RTL

- Shares the sampler's single trigger input between several trigger sources: front-panel buttons/switches, sequencer and synth.
- Holds one pending trigger per requester and arbitrates round-robin.
- Issues one trigger at a time to the sampler over a valid/ready handshake.
- Enforces a holdoff gap between issues so the sampler's DDR2 read/playback setup is never re-triggered mid-fetch.
- Sits between the trigger sources and the sampler, in the CLK200MHZ domain.

---
 rtl/sample_trigger_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/sample_trigger_arbiter.sv
// Round-robin trigger arbiter sharing one sampler trigger among NUM_REQ sources, with post-issue holdoff.
// Optional: define TRIG_DROP_CNT_EN to add the drop_count/drop_clear overwrite counter.
module sample_trigger_arbiter #(
    parameter int NUM_REQ  = 3,
    parameter int SAMPLE_W = 4,
    parameter int HOLDOFF  = 16
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*SAMPLE_W-1:0]  req_sample,
    output logic [NUM_REQ-1:0]           req_pending,
    output logic                         trig_valid,
    input  logic                         trig_ready,
    output logic [SAMPLE_W-1:0]          trig_sample,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id,
    output logic                         busy
`ifdef TRIG_DROP_CNT_EN
    ,
    input  logic                         drop_clear,
    output logic [15:0]                  drop_count
`endif
);

    localparam int GW = $clog2(NUM_REQ);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    logic [1:0]          state;
    logic [GW-1:0]       last;
    logic [7:0]          hold_cnt;
    logic [SAMPLE_W-1:0] slot [NUM_REQ];
    logic [NUM_REQ-1:0]  capture;
    logic                grant_hit;
    logic [GW-1:0]       grant_idx;
    logic                do_grant;

    always_comb begin
        capture = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            capture[i] = req_valid[i] && (req_sample[i*SAMPLE_W +: SAMPLE_W] != '0);
        end
    end

    // Search starts just past the last winner so every requester gets a turn.
    always_comb begin
        int idx;
        idx       = 0;
        grant_hit = 1'b0;
        grant_idx = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last) + k) % NUM_REQ;
            if (!grant_hit && req_pending[GW'(idx)]) begin
                grant_hit = 1'b1;
                grant_idx = GW'(idx);
            end
        end
    end

    assign do_grant = (state == ST_IDLE) && grant_hit;
    assign busy     = (state != ST_IDLE);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            last        <= GW'(NUM_REQ - 1);
            hold_cnt    <= '0;
            trig_valid  <= 1'b0;
            trig_sample <= '0;
            grant_id    <= '0;
            req_pending <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                slot[i] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_hit) begin
                        trig_sample <= slot[grant_idx];
                        grant_id    <= grant_idx;
                        last        <= grant_idx;
                        trig_valid  <= 1'b1;
                        state       <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (trig_ready) begin
                        trig_valid <= 1'b0;
                        if (HOLDOFF == 0) begin
                            state <= ST_IDLE;
                        end else begin
                            hold_cnt <= 8'(HOLDOFF - 1);
                            state    <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (hold_cnt == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        hold_cnt <= hold_cnt - 8'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // A capture on the grant edge keeps the slot pending with the new ID.
            for (int i = 0; i < NUM_REQ; i++) begin
                if (capture[i]) begin
                    slot[i]        <= req_sample[i*SAMPLE_W +: SAMPLE_W];
                    req_pending[i] <= 1'b1;
                end else if (do_grant && (grant_idx == GW'(i))) begin
                    req_pending[i] <= 1'b0;
                end
            end
        end
    end

`ifdef TRIG_DROP_CNT_EN
    logic [NUM_REQ-1:0] grant_mask;
    logic               overwrite;

    always_comb begin
        grant_mask = '0;
        if (do_grant) begin
            grant_mask[grant_idx] = 1'b1;
        end
    end

    assign overwrite = |(capture & req_pending & ~grant_mask);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            drop_count <= '0;
        end else if (drop_clear) begin
            drop_count <= '0;
        end else if (overwrite && (drop_count != 16'hFFFF)) begin
            drop_count <= drop_count + 16'd1;
        end
    end
`endif

endmodule
